// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Purpose  : Shared memory-bus types and constants used by the bus arbiter,
//            its interface and its tag-ownership table.
// Contents : BUS_COMMAND, MEM_SIZE, MEM_OWNER, TAG_ENTRY, XLEN, MEM_TAG_BITS
// Revision : 1.0  initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int MEM_TAG_BITS = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic     valid;
        MEM_OWNER owner;
    } TAG_ENTRY;

endpackage : mem_bus_arbiter_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter_if
// Purpose  : Bundles the fetch-side request/return, the data-side
//            request/return, the processor-to-memory bus and the arbiter's
//            status outputs.
// Modports : slave  - the arbiter (consumes requests and memory replies,
//                     drives acks, returns, bus fields and status)
//            master - the environment (front ends plus memory model)
// Revision : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    // Instruction-fetch side (loads only)
    logic                    i_req;
    logic [XLEN-1:0]         i_addr;
    logic                    i_ack;
    logic                    i_resp_valid;
    logic [63:0]             i_resp_data;

    // Data-access side
    logic                    d_req;
    BUS_COMMAND              d_cmd;
    logic [XLEN-1:0]         d_addr;
    logic [63:0]             d_wdata;
    MEM_SIZE                 d_size;
    logic                    d_ack;
    logic                    d_resp_valid;
    logic [63:0]             d_resp_data;

    // Shared memory bus
    BUS_COMMAND              proc2mem_command;
    logic [XLEN-1:0]         proc2mem_addr;
    logic [63:0]             proc2mem_data;
    MEM_SIZE                 proc2mem_size;
    logic [MEM_TAG_BITS-1:0] mem2proc_response;
    logic [63:0]             mem2proc_data;
    logic [MEM_TAG_BITS-1:0] mem2proc_tag;

    // Status
    logic [MEM_TAG_BITS-1:0] outstanding;
    logic                    spurious_tag;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_cmd, d_addr, d_wdata, d_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output i_ack, i_resp_valid, i_resp_data,
        output d_ack, d_resp_valid, d_resp_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        output outstanding, spurious_tag
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_cmd, d_addr, d_wdata, d_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  i_ack, i_resp_valid, i_resp_data,
        input  d_ack, d_resp_valid, d_resp_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
        input  outstanding, spurious_tag
    );

endinterface : mem_bus_arbiter_if
`default_nettype wire

// File: rtl/mem_tag_table.sv
`default_nettype none
// ============================================================================
// Module   : mem_tag_table
// Purpose  : Records which requester owns each outstanding load tag and keeps
//            a running count of live tags.
// Ports    : clock, reset_n          - clock, async active-low reset
//            alloc_valid/tag/owner   - claim a tag for a newly accepted load
//            ret_valid/tag           - tag seen on the return bus this cycle
//            ret_hit/ret_owner       - lookup result for the returning tag
//            outstanding             - number of valid entries
// Revision : 1.0  initial release
// ============================================================================
module mem_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    alloc_valid,
    input  logic [MEM_TAG_BITS-1:0] alloc_tag,
    input  MEM_OWNER                alloc_owner,
    input  logic                    ret_valid,
    input  logic [MEM_TAG_BITS-1:0] ret_tag,
    output logic                    ret_hit,
    output MEM_OWNER                ret_owner,
    output logic [MEM_TAG_BITS-1:0] outstanding
);

    TAG_ENTRY                r_table [NUM_TAGS];
    logic [MEM_TAG_BITS-1:0] r_outstanding;

    TAG_ENTRY w_ret_entry;
    TAG_ENTRY w_alloc_entry;
    logic     w_alloc_in_range;
    logic     w_alloc_new;

    // Tags beyond the configured table size never hit and are never stored.
    always_comb begin
        w_ret_entry      = '0;
        w_alloc_entry    = '0;
        w_alloc_in_range = int'(alloc_tag) < NUM_TAGS;
        if (int'(ret_tag) < NUM_TAGS) begin
            w_ret_entry = r_table[ret_tag];
        end
        if (w_alloc_in_range) begin
            w_alloc_entry = r_table[alloc_tag];
        end
    end

    assign ret_hit   = ret_valid && w_ret_entry.valid;
    assign ret_owner = w_ret_entry.owner;

    // An allocation only adds a live tag if its slot is free, or is being
    // freed by a return this very cycle; that keeps the count equal to the
    // number of valid entries even if memory reuses a busy tag.
    assign w_alloc_new = alloc_valid && w_alloc_in_range &&
                         (!w_alloc_entry.valid ||
                          (ret_hit && (ret_tag == alloc_tag)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_TAGS; k++) begin
                r_table[k] <= '0;
            end
            r_outstanding <= '0;
        end else begin
            // Retire first; a same-tag allocation below overrides the clear,
            // so the freshly issued load keeps its entry.
            if (ret_hit) begin
                r_table[ret_tag] <= '0;
            end
            if (alloc_valid && w_alloc_in_range) begin
                r_table[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
            end
            case ({w_alloc_new, ret_hit})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding = r_outstanding;

endmodule : mem_tag_table
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares the processor-to-memory bus between the fetch (I) side
//            and the data (D) side, tracks load-tag ownership and steers
//            tagged returns back to their owner.
// Ports    : clock, reset_n - clock, async active-low reset
//            bus            - mem_bus_arbiter_if.slave: both requesters,
//                             the memory bus and outstanding/spurious_tag
// Params   : STARVE_LIMIT   - denied I cycles before I takes priority
//            NUM_TAGS       - size of the tag space (tag 0 = none)
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    mem_bus_arbiter_if.slave bus
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic                  r_i_resp_valid;
    logic [63:0]           r_i_resp_data;
    logic                  r_d_resp_valid;
    logic [63:0]           r_d_resp_data;
    logic                  r_spurious;

    logic     w_i_wins;
    logic     w_d_wins;
    logic     w_mem_accept;
    logic     w_i_ack;
    logic     w_d_ack;
    logic     w_alloc_valid;
    MEM_OWNER w_alloc_owner;
    logic     w_ret_valid;
    logic     w_ret_hit;
    MEM_OWNER w_ret_owner;
    logic     w_route_i;
    logic     w_route_d;

    // Grant: D normally wins; a starved I side wins once its count saturates.
    // Nothing is granted while reset is held so the bus stays idle.
    assign w_i_wins     = reset_n && bus.i_req &&
                          (!bus.d_req || (r_starve_cnt >= c_STARVE_MAX));
    assign w_d_wins     = reset_n && bus.d_req && !w_i_wins;
    assign w_mem_accept = (bus.mem2proc_response != '0);
    assign w_i_ack      = w_i_wins && w_mem_accept;
    assign w_d_ack      = w_d_wins && w_mem_accept;

    assign bus.i_ack = w_i_ack;
    assign bus.d_ack = w_d_ack;

    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.proc2mem_size    = DOUBLE;
        if (w_i_wins) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = bus.i_addr;
        end else if (w_d_wins) begin
            bus.proc2mem_command = bus.d_cmd;
            bus.proc2mem_addr    = bus.d_addr;
            bus.proc2mem_data    = bus.d_wdata;
            bus.proc2mem_size    = bus.d_size;
        end
    end

    // Only loads produce a return, so stores never claim a tag.
    assign w_alloc_valid = w_i_ack || (w_d_ack && (bus.d_cmd == BUS_LOAD));
    assign w_alloc_owner = w_i_ack ? OWNER_I : OWNER_D;
    assign w_ret_valid   = (bus.mem2proc_tag != '0);

    mem_tag_table #(
        .NUM_TAGS    (NUM_TAGS)
    ) u_tag_table (
        .clock       (clock),
        .reset_n     (reset_n),
        .alloc_valid (w_alloc_valid),
        .alloc_tag   (bus.mem2proc_response),
        .alloc_owner (w_alloc_owner),
        .ret_valid   (w_ret_valid),
        .ret_tag     (bus.mem2proc_tag),
        .ret_hit     (w_ret_hit),
        .ret_owner   (w_ret_owner),
        .outstanding (bus.outstanding)
    );

    assign w_route_i = w_ret_hit && (w_ret_owner == OWNER_I);
    assign w_route_d = w_ret_hit && (w_ret_owner == OWNER_D);

    // Starvation count: a granted-but-rejected I request holds its count so
    // it keeps priority on the retry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (!bus.i_req || w_i_ack) begin
            r_starve_cnt <= '0;
        end else if (!w_i_wins && (r_starve_cnt < c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Return path: valids pulse for one cycle, data holds its last value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_i_resp_valid <= 1'b0;
            r_i_resp_data  <= '0;
            r_d_resp_valid <= 1'b0;
            r_d_resp_data  <= '0;
            r_spurious     <= 1'b0;
        end else begin
            r_i_resp_valid <= w_route_i;
            r_d_resp_valid <= w_route_d;
            r_spurious     <= w_ret_valid && !w_ret_hit;
            if (w_route_i) begin
                r_i_resp_data <= bus.mem2proc_data;
            end
            if (w_route_d) begin
                r_d_resp_data <= bus.mem2proc_data;
            end
        end
    end

    assign bus.i_resp_valid = r_i_resp_valid;
    assign bus.i_resp_data  = r_i_resp_data;
    assign bus.d_resp_valid = r_d_resp_valid;
    assign bus.d_resp_data  = r_d_resp_data;
    assign bus.spurious_tag = r_spurious;

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter. A tag-ownership model
//            predicts every output on each falling edge; directed scenarios
//            add hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .NUM_TAGS     (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid   [16];
    bit          m_owner_d [16];
    int          m_starve = 0;
    logic        e_i_rv = 1'b0, e_d_rv = 1'b0, e_spur = 1'b0;
    logic [63:0] e_i_rd = '0, e_d_rd = '0;

    always @(negedge clock) begin : compare
        int          win;   // 0 none, 1 I, 2 D
        bit          acc;
        int          pop;
        int          t;
        int          r;
        logic [1:0]  x_cmd;
        logic [31:0] x_addr;
        logic [63:0] x_data;
        logic [1:0]  x_size;
        if (!reset_n) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k]   = 1'b0;
                m_owner_d[k] = 1'b0;
            end
            m_starve = 0;
            e_i_rv = 1'b0; e_d_rv = 1'b0; e_spur = 1'b0;
            e_i_rd = '0;   e_d_rd = '0;
            win = 0;
        end else if (bus_if.i_req && (!bus_if.d_req || m_starve >= STARVE_LIMIT)) begin
            win = 1;
        end else if (bus_if.d_req) begin
            win = 2;
        end else begin
            win = 0;
        end
        acc = (win != 0) && (bus_if.mem2proc_response != 0);
        x_cmd = 2'd0; x_addr = '0; x_data = '0; x_size = 2'd3;
        if (win == 1) begin
            x_cmd = 2'd1; x_addr = bus_if.i_addr;
        end else if (win == 2) begin
            x_cmd  = bus_if.d_cmd;   x_addr = bus_if.d_addr;
            x_data = bus_if.d_wdata; x_size = bus_if.d_size;
        end
        pop = 0;
        for (int k = 0; k < 16; k++) pop += int'(m_valid[k]);

        check("cyc_i_ack",        bus_if.i_ack,            (win == 1) && acc);
        check("cyc_d_ack",        bus_if.d_ack,            (win == 2) && acc);
        check("cyc_bus_cmd",      bus_if.proc2mem_command, x_cmd);
        check("cyc_bus_addr",     bus_if.proc2mem_addr,    x_addr);
        check("cyc_bus_data",     bus_if.proc2mem_data,    x_data);
        check("cyc_bus_size",     bus_if.proc2mem_size,    x_size);
        check("cyc_i_resp_valid", bus_if.i_resp_valid,     e_i_rv);
        check("cyc_i_resp_data",  bus_if.i_resp_data,      e_i_rd);
        check("cyc_d_resp_valid", bus_if.d_resp_valid,     e_d_rv);
        check("cyc_d_resp_data",  bus_if.d_resp_data,      e_d_rd);
        check("cyc_spurious",     bus_if.spurious_tag,     e_spur);
        check("cyc_outstanding",  bus_if.outstanding,      pop);

        if (reset_n) begin
            t = int'(bus_if.mem2proc_tag);
            r = int'(bus_if.mem2proc_response);
            e_i_rv = 1'b0; e_d_rv = 1'b0; e_spur = 1'b0;
            if (t != 0) begin
                if (m_valid[t]) begin
                    if (m_owner_d[t]) begin e_d_rv = 1'b1; e_d_rd = bus_if.mem2proc_data; end
                    else              begin e_i_rv = 1'b1; e_i_rd = bus_if.mem2proc_data; end
                    m_valid[t] = 1'b0;
                end else begin
                    e_spur = 1'b1;
                end
            end
            if (acc && (win == 1 || bus_if.d_cmd == BUS_LOAD)) begin
                m_valid[r]   = 1'b1;
                m_owner_d[r] = (win == 2);
            end
            if (!bus_if.i_req || (win == 1 && acc)) m_starve = 0;
            else if (win != 1 && m_starve < STARVE_LIMIT) m_starve++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        bus_if.i_req = 1'b0;  bus_if.i_addr = '0;
        bus_if.d_req = 1'b0;  bus_if.d_cmd = BUS_NONE; bus_if.d_addr = '0;
        bus_if.d_wdata = '0;  bus_if.d_size = DOUBLE;
        bus_if.mem2proc_response = '0; bus_if.mem2proc_data = '0; bus_if.mem2proc_tag = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic d_drive(input BUS_COMMAND cmd, input logic [31:0] a, input logic [63:0] wd,
                           input MEM_SIZE sz, input logic [3:0] resp);
        bus_if.d_req = 1'b1; bus_if.d_cmd = cmd; bus_if.d_addr = a;
        bus_if.d_wdata = wd; bus_if.d_size = sz; bus_if.mem2proc_response = resp;
    endtask

    task automatic ret(input logic [3:0] tag, input logic [63:0] data);
        bus_if.mem2proc_tag = tag; bus_if.mem2proc_data = data;
    endtask

    initial begin
        idle();
        step(); step();
        check("rst_outstanding", bus_if.outstanding, 0);
        check("rst_bus_cmd",     bus_if.proc2mem_command, BUS_NONE);
        check("rst_bus_size",    bus_if.proc2mem_size, DOUBLE);
        check("rst_d_resp_data", bus_if.d_resp_data, 0);
        reset_n = 1'b1;
        step();

        // Both sides request, D wins and memory gives tag 3; tag 3 returns.
        d_drive(BUS_LOAD, 32'h100, 64'h0, DOUBLE, 4'd3);
        bus_if.i_req = 1'b1; bus_if.i_addr = 32'h200;
        #1;
        check("t1_d_ack", bus_if.d_ack, 1);
        check("t1_i_ack", bus_if.i_ack, 0);
        check("t1_addr",  bus_if.proc2mem_addr, 32'h100);
        step(); idle();
        check("t1_outstanding", bus_if.outstanding, 1);
        ret(4'd3, 64'hDEAD);
        step(); idle();
        check("t1_d_resp_valid", bus_if.d_resp_valid, 1);
        check("t1_d_resp_data",  bus_if.d_resp_data, 64'hDEAD);
        check("t1_i_resp_valid", bus_if.i_resp_valid, 0);
        check("t1_outstanding0", bus_if.outstanding, 0);
        step();
        check("t1_pulse_end", bus_if.d_resp_valid, 0);
        check("t1_data_hold", bus_if.d_resp_data, 64'hDEAD);

        // Starvation: D stores every cycle, I wins on the 5th cycle.
        d_drive(BUS_STORE, 32'h300, 64'h55, WORD, 4'd1);
        bus_if.i_req = 1'b1; bus_if.i_addr = 32'h400;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("t2_i_ack_c%0d", c), bus_if.i_ack, c == 5);
            check($sformatf("t2_d_ack_c%0d", c), bus_if.d_ack, c != 5);
            step();
        end
        #1;
        check("t2_d_after", bus_if.d_ack, 1);
        check("t2_i_after", bus_if.i_ack, 0);
        step(); idle();
        check("t2_outstanding", bus_if.outstanding, 1);
        ret(4'd1, 64'h1111);
        step(); idle();
        check("t2_i_resp_valid", bus_if.i_resp_valid, 1);
        check("t2_i_resp_data",  bus_if.i_resp_data, 64'h1111);

        // Store is not recorded; its tag coming back is spurious.
        d_drive(BUS_STORE, 32'h40, 64'hCAFE, WORD, 4'd5);
        #1;
        check("t3_d_ack", bus_if.d_ack, 1);
        check("t3_cmd",   bus_if.proc2mem_command, BUS_STORE);
        check("t3_data",  bus_if.proc2mem_data, 64'hCAFE);
        step(); idle();
        check("t3_outstanding", bus_if.outstanding, 0);
        ret(4'd5, 64'hBEEF);
        step(); idle();
        check("t3_spurious",    bus_if.spurious_tag, 1);
        check("t3_no_d_valid",  bus_if.d_resp_valid, 0);
        check("t3_d_data_hold", bus_if.d_resp_data, 64'hDEAD);
        step();
        check("t3_spurious_end", bus_if.spurious_tag, 0);

        // Tag 7 returns to I while a D load is given tag 7 in the same cycle.
        bus_if.i_req = 1'b1; bus_if.i_addr = 32'h700; bus_if.mem2proc_response = 4'd7;
        #1;
        check("t4_i_ack", bus_if.i_ack, 1);
        step(); idle();
        check("t4_outstanding1", bus_if.outstanding, 1);
        ret(4'd7, 64'h7777);
        d_drive(BUS_LOAD, 32'h500, 64'h0, DOUBLE, 4'd7);
        #1;
        check("t4_d_ack", bus_if.d_ack, 1);
        step(); idle();
        check("t4_i_resp_valid", bus_if.i_resp_valid, 1);
        check("t4_i_resp_data",  bus_if.i_resp_data, 64'h7777);
        check("t4_outstanding",  bus_if.outstanding, 1);
        ret(4'd7, 64'h8888);
        step(); idle();
        check("t4_d_resp_valid", bus_if.d_resp_valid, 1);
        check("t4_d_resp_data",  bus_if.d_resp_data, 64'h8888);
        check("t4_not_spurious", bus_if.spurious_tag, 0);
        check("t4_outstanding0", bus_if.outstanding, 0);

        // Memory rejects for three cycles, then accepts with tag 9.
        d_drive(BUS_LOAD, 32'h600, 64'h66, HALF, 4'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("t5_no_ack_%0d", c), bus_if.d_ack, 0);
            check($sformatf("t5_addr_%0d", c),   bus_if.proc2mem_addr, 32'h600);
            step();
            check($sformatf("t5_outst_%0d", c),  bus_if.outstanding, 0);
        end
        bus_if.mem2proc_response = 4'd9;
        #1;
        check("t5_ack", bus_if.d_ack, 1);
        step(); idle();
        check("t5_outstanding1", bus_if.outstanding, 1);
        ret(4'd9, 64'h9999);
        step(); idle();
        check("t5_d_resp_data", bus_if.d_resp_data, 64'h9999);

        // Reset with two loads in flight; a later return is spurious.
        d_drive(BUS_LOAD, 32'h800, 64'h0, DOUBLE, 4'd2);
        step(); idle();
        bus_if.i_req = 1'b1; bus_if.i_addr = 32'h900; bus_if.mem2proc_response = 4'd4;
        step(); idle();
        check("t6_outstanding2", bus_if.outstanding, 2);
        d_drive(BUS_LOAD, 32'hA00, 64'h0, DOUBLE, 4'd0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_outstanding", bus_if.outstanding, 0);
        check("t6_rst_cmd",         bus_if.proc2mem_command, BUS_NONE);
        check("t6_rst_d_ack",       bus_if.d_ack, 0);
        check("t6_rst_d_data",      bus_if.d_resp_data, 0);
        check("t6_rst_i_data",      bus_if.i_resp_data, 0);
        step();
        reset_n = 1'b1; idle();
        step();
        ret(4'd2, 64'h2222);
        step(); idle();
        check("t6_spurious",    bus_if.spurious_tag, 1);
        check("t6_outstanding", bus_if.outstanding, 0);
        check("t6_no_d_valid",  bus_if.d_resp_valid, 0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
